// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data-memory bus between the memory-stage LSU
// (master) and the data memory (slave).
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_be/bus_wdata
// and holds all of them stable until a rising clock edge samples bus_ack=1;
// that same edge samples bus_rdata. bus_ack outside an active request is
// ignored.
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit. Launches one bus access per
// M-stage load/store, stalls the pipeline until the access completes (or
// times out), and returns aligned, extended load data in the DONE cycle.
// Optional feature macro: LSU_ALIGN_CHECK_EN (misaligned half/word accesses
// skip the bus and pulse align_fault instead).
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemtoRegM,
  input  logic                 MemWriteM,
  input  logic [1:0]           SizeM,
  input  logic                 SignedM,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          WriteDataM,
  output logic [31:0]          ReadDataM,
  output logic                 StallM,
  mem_stage_lsu_if.master      bus,
  output logic                 bus_err,
  output logic                 align_fault,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_in;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign req_in = MemtoRegM | MemWriteM;

`ifdef LSU_ALIGN_CHECK_EN
  logic misaligned;
  logic af_q;
  // Half needs addr[0]=0, word (incl. size 11) needs addr[1:0]=0.
  assign misaligned = (SizeM == 2'b01) ? ALUResultM[0] :
                      (SizeM[1])       ? (ALUResultM[1:0] != 2'b00) : 1'b0;
  assign align_fault = af_q;
`else
  // Without the check, low address bits only select lanes.
  assign align_fault = 1'b0;
`endif

  assign StallM        = ((state_q == IDLE) & req_in) | (state_q == REQ) | (state_q == WAIT);
  assign ReadDataM     = rdata_q;
  assign bus_err       = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign dbg_state_o   = state_q;

  // Lane enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteDataM;
    case (SizeM)
      2'b00: begin
        be_d    = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
      end
    endcase
  end

  // Select the addressed lane of bus_rdata and zero/sign-extend it.
  always_comb begin
    byte_sel = bus.bus_rdata[7:0];
    case (addr_lo_q)
      2'd0: byte_sel = bus.bus_rdata[7:0];
      2'd1: byte_sel = bus.bus_rdata[15:8];
      2'd2: byte_sel = bus.bus_rdata[23:16];
      default: byte_sel = bus.bus_rdata[31:24];
    endcase
    half_sel = addr_lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = bus.bus_rdata;
    endcase
  end

  // Access FSM: IDLE launches, REQ/WAIT hold the bus until ack or timeout,
  // DONE presents the result for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_lo_q <= 2'b00;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      af_q      <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      af_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_in) begin
            addr_lo_q <= ALUResultM[1:0];
            size_q    <= SizeM;
            signed_q  <= SignedM;
            we_q      <= MemWriteM;
            addr_q    <= {ALUResultM[31:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
`ifdef LSU_ALIGN_CHECK_EN
            if (misaligned) begin
              state_q <= DONE;
              rdata_q <= 32'h0;
              af_q    <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
`else
            state_q <= REQ;
            req_q   <= 1'b1;
`endif
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_val;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CW'(1);
          end
        end
        WAIT: begin
          if (bus.bus_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_val;
          end else if (cnt_q == TMO) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          // Request inputs are still asserted here; they belong to the
          // finished instruction and must not start a new access.
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Sits directly downstream of the execute→memory pipeline register.
- Consumes ALUResultM (address), WriteDataM and the M-stage control bits. Drives a req/ack data-memory bus.
- Returns aligned, extended ReadDataM to the writeback register.
- Asserts StallM to freeze the pipeline while a multi-cycle access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT before the access is aborted with bus error; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- MemtoRegM  in  1  load request this cycle
- MemWriteM  in  1  store request this cycle; if both MemtoRegM and MemWriteM are set, the store wins
- SizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- SignedM  in  1  sign-extend byte/half loads
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-justified
- ReadDataM  out  32  load result, valid in DONE
- StallM  out  1  freeze F/D/E/M registers
- bus_req  out  1  memory request
- bus_we  out  1  write strobe
- bus_addr  out  32  word address {addr[31:2],2'b00}
- bus_be  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  access complete
- bus_err  out  1  one-cycle pulse on timeout
- align_fault  out  1  one-cycle pulse on misaligned access (feature only)

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; wait counter=0.
  - All outputs 0: ReadDataM=0, StallM=0, bus_req=0, bus_err=0, align_fault=0.
  - Reset mid-access: the next cycle is IDLE with bus_req=0. A late bus_ack is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If MemtoRegM|MemWriteM, latch address, size, signed, we and data, then go to REQ.
  - StallM asserts combinationally in this same cycle.
  - Otherwise stay in IDLE with StallM=0.
- REQ:
  - bus_req=1.
  - bus_ack → capture bus_rdata, go to DONE.
  - No ack → go to WAIT; counter=1.
- WAIT:
  - bus_req held at 1; address, be and wdata stable.
  - bus_ack → capture bus_rdata, go to DONE.
  - Counter reaching TIMEOUT_CYCLES → go to DONE, force captured data=0, pulse bus_err.
  - Otherwise counter increments.
- DONE:
  - StallM=0 and bus_req=0; ReadDataM is valid. The pipeline advances at the end of this cycle.
  - Always returns to IDLE. The still-present request inputs in DONE must not relaunch an access.
- Latency: zero-wait memory gives 2 stall cycles (IDLE, REQ), with data presented in the 3rd cycle. Each wait cycle adds 1.
- StallM = (state==IDLE & request) | state==REQ | state==WAIT.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Store data:
  - Byte: replicated x4.
  - Half: WriteDataM[15:0] replicated x2.
  - Word: unchanged.
- Load data:
  - Byte: lane addr[1:0] selected. Half: lane addr[1] selected.
  - Zero-extended, or sign-extended when SignedM=1. Word loads unchanged.
- Stores: ReadDataM=0 in DONE.
- ReadDataM holds its value outside DONE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus cycle.
  - The FSM goes IDLE→DONE with one stall cycle.
  - align_fault pulses in DONE and ReadDataM=0.
- Undefined:
  - Low address bits beyond lane selection are ignored (word forced aligned; half uses addr[1] only).
  - align_fault is tied to 0.

Test Plan:
- Word load, addr 0x100, bus_ack in REQ cycle, rdata 0xDEADBEEF → bus_be=1111, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- Signed byte load, addr 0x103, rdata 0x80112233, SignedM=1 → bus_be=1000, ReadDataM=0xFFFFFF80; with SignedM=0 → 0x00000080.
- Half store, addr 0x202, WriteDataM=0x0000ABCD, ack after 3 wait cycles → bus_be=1100, bus_wdata=0xABCDABCD, req held stable, StallM high 5 cycles.
- No ack, TIMEOUT_CYCLES=4 → bus_err pulse exactly once, ReadDataM=0, FSM back to IDLE, StallM released.
- Reset asserted in WAIT, then ack one cycle later → bus_req=0 after reset, ack ignored, all outputs 0.
- With LSU_ALIGN_CHECK_EN, word load at 0x101 → no bus_req, align_fault pulse, one stall cycle; without the macro → bus_addr=0x100, be=1111.
